// File: rtl/arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : arb_pkg
// Brief   : Shared types and round-robin pick helpers for rr_arbiter8.
// Revision: 1.0  initial release
// ============================================================================
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int ID_W  = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   // Downward scan so the entry closest to ptr is written last and wins.
   function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                input logic [ID_W-1:0]  ptr);
      logic [N_REQ-1:0] win;
      logic [ID_W-1:0]  idx;
      win = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         idx = ptr + ID_W'(i);
         if (req[idx]) begin
            win      = '0;
            win[idx] = 1'b1;
         end
      end
      return win;
   endfunction

   function automatic logic [ID_W-1:0] onehot_to_id(input logic [N_REQ-1:0] oh);
      logic [ID_W-1:0] id;
      id = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) id = id | ID_W'(i);
      end
      return id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter8_or8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : MyOr8way
// Brief   : Any-request detect across the eight request lines.
// Revision: 1.0  initial release
// ============================================================================
module MyOr8way (
   input  logic [7:0] req,
   output logic       any
);

   assign any = |req;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : rr_arbiter8
// Brief   : 8-way round-robin arbiter with registered one-hot grant held
//           until the owner releases. Optional hold timeout via ARB_TIMEOUT_EN.
// Revision: 1.0  initial release
// ============================================================================
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] REQ,
   output logic [7:0] GNT,
   output logic       GNT_VLD,
   output logic [2:0] GNT_ID,
   output logic       TMO
);

   // Marker only: a MAX_HOLD outside 2..65535 is not a supported build.
   if (MAX_HOLD < 2 || MAX_HOLD > 65535) begin : g_max_hold_illegal
   end

   arb_state_t        state_q, state_d;
   logic [ID_W-1:0]   ptr_q, ptr_d;
   logic [N_REQ-1:0]  gnt_q, gnt_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic              gnt_vld_q, gnt_vld_d;

   logic              any;
   logic [ID_W-1:0]   ptr_next;
   logic [ID_W-1:0]   pick_base;
   logic [N_REQ-1:0]  pick;
   logic              load;
   logic              drop;

`ifdef ARB_TIMEOUT_EN
   localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);
   logic [15:0]       cnt_q, cnt_d;
   logic              tmo_q, tmo_d;
`endif

   MyOr8way u_any (
      .req (REQ),
      .any (any)
   );

   // In GRANT the owner sits last in the scan, so a revoke never re-picks it.
   assign ptr_next  = gnt_id_q + 3'd1;
   assign pick_base = (state_q == IDLE) ? ptr_q : ptr_next;
   assign pick      = rr_pick(REQ, pick_base);

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      gnt_d     = gnt_q;
      gnt_id_d  = gnt_id_q;
      gnt_vld_d = gnt_vld_q;
      load      = 1'b0;
      drop      = 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      tmo_d     = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            load = any;
         end
         GRANT: begin
            if (!REQ[gnt_id_q]) begin
               ptr_d = ptr_next;
               load  = |pick;
               drop  = ~(|pick);
            end
`ifdef ARB_TIMEOUT_EN
            else if (cnt_q == HOLD_LAST) begin
               cnt_d = '0;
               if (|(REQ & ~gnt_q)) begin
                  ptr_d = ptr_next;
                  load  = 1'b1;
                  tmo_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
`endif
         end
         default: begin
            drop = 1'b1;
         end
      endcase

      if (load) begin
         state_d   = GRANT;
         gnt_d     = pick;
         gnt_id_d  = onehot_to_id(pick);
         gnt_vld_d = 1'b1;
`ifdef ARB_TIMEOUT_EN
         cnt_d     = '0;
`endif
      end else if (drop) begin
         state_d   = IDLE;
         gnt_d     = '0;
         gnt_id_d  = '0;
         gnt_vld_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_d     = '0;
`endif
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         gnt_q     <= '0;
         gnt_id_q  <= '0;
         gnt_vld_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= '0;
         tmo_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         gnt_q     <= gnt_d;
         gnt_id_q  <= gnt_id_d;
         gnt_vld_q <= gnt_vld_d;
`ifdef ARB_TIMEOUT_EN
         cnt_q     <= cnt_d;
         tmo_q     <= tmo_d;
`endif
      end
   end

   assign GNT     = gnt_q;
   assign GNT_VLD = gnt_vld_q;
   assign GNT_ID  = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
   assign TMO     = tmo_q;
`else
   assign TMO     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_rr_arbiter8
// Brief   : Scoreboard bench for rr_arbiter8; timeout cases build only with
//           ARB_TIMEOUT_EN defined.
// Revision: 1.0  initial release
// ============================================================================
module tb_rr_arbiter8;

   localparam int MH = 4;

   logic       CLK = 1'b0;
   logic       RST_N;
   logic [7:0] REQ;
   logic [7:0] GNT;
   logic       GNT_VLD;
   logic [2:0] GNT_ID;
   logic       TMO;

   typedef struct packed {
      logic [7:0] gnt;
      logic [2:0] id;
      logic       vld;
      logic       tmo;
   } exp_t;

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;
   int   m_owner;
   int   m_ptr;
   int   m_cnt;

   rr_arbiter8 #(.MAX_HOLD(MH)) dut (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .REQ     (REQ),
      .GNT     (GNT),
      .GNT_VLD (GNT_VLD),
      .GNT_ID  (GNT_ID),
      .TMO     (TMO)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic int search(input logic [7:0] r, input int start);
      for (int k = 0; k < 8; k++) begin
         if (r[(start + k) % 8]) return (start + k) % 8;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_cnt   = 0;
   endtask

   task automatic model_step(input logic [7:0] r, output exp_t e);
      logic t;
      t = 1'b0;
      if (m_owner < 0) begin
         m_owner = search(r, m_ptr);
         m_cnt   = 0;
      end else if (!r[m_owner]) begin
         m_ptr   = (m_owner + 1) % 8;
         m_owner = search(r, m_ptr);
         m_cnt   = 0;
      end else begin
`ifdef ARB_TIMEOUT_EN
         if (m_cnt == MH - 1) begin
            if ((r & ~(8'd1 << m_owner)) != 8'd0) begin
               m_ptr   = (m_owner + 1) % 8;
               m_owner = search(r, m_ptr);
               t       = 1'b1;
            end
            m_cnt = 0;
         end else begin
            m_cnt++;
         end
`endif
      end
      e.gnt = (m_owner < 0) ? 8'h00 : (8'd1 << m_owner);
      e.id  = (m_owner < 0) ? 3'd0 : 3'(m_owner);
      e.vld = (m_owner >= 0);
      e.tmo = t;
   endtask

   task automatic cyc(input logic [7:0] r);
      exp_t e;
      exp_t got;
      REQ = r;
      model_step(r, e);
      sb_q.push_back(e);
      @(posedge CLK);
      #1;
      got = sb_q.pop_front();
      check_eq("gnt", GNT, got.gnt);
      check_eq("gnt_id", GNT_ID, got.id);
      check_eq("gnt_vld", GNT_VLD, got.vld);
      check_eq("tmo", TMO, got.tmo);
   endtask

   task automatic do_reset(input logic [7:0] r);
      REQ   = r;
      RST_N = 1'b0;
      #2;
      check_eq("rst_gnt", GNT, 8'h00);
      check_eq("rst_vld", GNT_VLD, 1'b0);
      check_eq("rst_id", GNT_ID, 3'd0);
      check_eq("rst_tmo", TMO, 1'b0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      model_reset();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      model_reset();

      do_reset(8'hFF);
      cyc(8'hFF);
      check_eq("t1_first", GNT, 8'h01);

      do_reset(8'h00);
      cyc(8'h08);
      check_eq("t2_id", GNT_ID, 3'd3);
      cyc(8'h08);
      cyc(8'h00);
      check_eq("t2_idle", GNT, 8'h00);

      do_reset(8'hFF);
      cyc(8'hFF);
      for (int k = 1; k <= 8; k++) begin
         logic [7:0] m;
         m = 8'hFF & ~(8'd1 << ((k - 1) % 8));
         cyc(m);
         check_eq("t3_order", GNT_ID, 32'(k % 8));
         cyc(8'hFF);
      end

      do_reset(8'h00);
      cyc(8'h04);
      cyc(8'h26);
      cyc(8'h22);
      check_eq("t4_hand", GNT, 8'h20);
      cyc(8'h22);
      cyc(8'h02);
      check_eq("t4_next", GNT, 8'h02);

`ifdef ARB_TIMEOUT_EN
      do_reset(8'h00);
      cyc(8'h03);
      check_eq("t5_first", GNT, 8'h01);
      for (int k = 0; k < 3; k++) begin
         cyc(8'h03);
         check_eq("t5_hold", GNT, 8'h01);
      end
      cyc(8'h03);
      check_eq("t5_revoke", GNT, 8'h02);
      check_eq("t5_tmo", TMO, 1'b1);
      cyc(8'h03);
      check_eq("t5_tmo_end", TMO, 1'b0);
      do_reset(8'h00);
      for (int k = 0; k < 10; k++) begin
         cyc(8'h01);
         check_eq("t5_lone", GNT, 8'h01);
         check_eq("t5_lone_tmo", TMO, 1'b0);
      end
`endif

      do_reset(8'h00);
      cyc(8'h08);
      cyc(8'h10);
      cyc(8'h10);
      check_eq("t6_pre", GNT, 8'h10);
      #2;
      RST_N = 1'b0;
      #1;
      check_eq("t6_async_gnt", GNT, 8'h00);
      check_eq("t6_async_vld", GNT_VLD, 1'b0);
      check_eq("t6_async_id", GNT_ID, 3'd0);
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      model_reset();
      cyc(8'h11);
      check_eq("t6_ptr0", GNT, 8'h01);
      cyc(8'h10);
      check_eq("t6_regrant", GNT, 8'h10);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
